// File: rtl/clip_arbiter.sv
// Triangle-atomic round-robin arbiter in front of the shared triangle_clip pipeline.
// Issue is throttled by a triangle credit counter because the clip pipeline has no backpressure.
module clip_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned CREDITS = 8,
  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [NUM_REQ-1:0]                req_valid_in,
  input  logic [NUM_REQ-1:0][3:0][31:0]     req_vertex_in,
  output logic [NUM_REQ-1:0]                req_ready_out,
  input  logic                              credit_in,
  output logic                              valid_out,
  output logic [3:0][31:0]                  vertex_out,
  output logic [ID_WIDTH-1:0]               source_out,
  output logic                              last_out,
  output logic                              busy_out,
  output logic                              error_out
);

  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam int unsigned VCW = 2;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [VCW-1:0]        vcount_q, vcount_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic                  error_d;
  logic                  valid_d;
  logic                  last_d;
  logic [3:0][31:0]      vertex_d;
  logic [ID_WIDTH-1:0]   source_d;
  logic                  grant_take_c;
  logic                  hs_c;

  // First valid requester strictly after the previous grant, wrapping modulo NUM_REQ.
  function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                  input logic [ID_WIDTH-1:0] last);
    logic [ID_WIDTH-1:0] sel;
    logic                found;
    int unsigned         idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last) + i) % NUM_REQ;
      if (!found && v[ID_WIDTH'(idx)]) begin
        sel   = ID_WIDTH'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign hs_c     = (state_q == GRANT) && req_valid_in[grant_q];
  assign busy_out = (state_q == GRANT);

  // Ready is a decode of registered state only, so there is no valid-to-ready path.
  always_comb begin
    req_ready_out = '0;
    if (state_q == GRANT) req_ready_out[grant_q] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    vcount_d     = vcount_q;
    credits_d    = credits_q;
    error_d      = error_out;
    valid_d      = 1'b0;
    last_d       = 1'b0;
    vertex_d     = vertex_out;
    source_d     = source_out;
    grant_take_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if ((credits_q != '0) && (|req_valid_in)) begin
          grant_d      = rr_pick(req_valid_in, last_grant_q);
          last_grant_d = grant_d;
          vcount_d     = '0;
          grant_take_c = 1'b1;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        if (hs_c) begin
          vertex_d = req_vertex_in[grant_q];
          source_d = grant_q;
          valid_d  = 1'b1;
          last_d   = (vcount_q == VCW'(2));
          vcount_d = vcount_q + VCW'(1);
          if (vcount_q == VCW'(2)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A grant and a returned credit in the same cycle cancel out.
    unique case ({grant_take_c, credit_in})
      2'b10: credits_d = credits_q - CW'(1);
      2'b01: begin
        if (credits_q == CW'(CREDITS)) error_d = 1'b1;
        else                           credits_d = credits_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      vcount_q     <= '0;
      credits_q    <= CW'(CREDITS);
      error_out    <= 1'b0;
      valid_out    <= 1'b0;
      last_out     <= 1'b0;
      vertex_out   <= '0;
      source_out   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      vcount_q     <= vcount_d;
      credits_q    <= credits_d;
      error_out    <= error_d;
      valid_out    <= valid_d;
      last_out     <= last_d;
      vertex_out   <= vertex_d;
      source_out   <= source_d;
    end
  end

endmodule

// File: tb/tb_clip_arbiter.sv
// Bench for clip_arbiter: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against a transaction-level model of the arbiter.
module tb_clip_arbiter;

  localparam int NR = 3;
  localparam int CR = 3;
  localparam int IW = $clog2(NR);

  logic                       clk;
  logic                       rst_n;
  logic [NR-1:0]              req_valid;
  logic [NR-1:0][3:0][31:0]   req_vertex;
  logic [NR-1:0]              req_ready;
  logic                       credit;
  logic                       valid_out;
  logic [3:0][31:0]           vertex_out;
  logic [IW-1:0]              source_out;
  logic                       last_out;
  logic                       busy;
  logic                       error;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  int srcs[$];

  // Model state: owner is the granted requester or -1 when nobody holds the pipeline.
  int           m_owner, m_sent, m_credits, m_lastg;
  bit           m_err;
  bit           e_valid, e_last;
  logic [127:0] e_vertex;
  int           e_source;

  clip_arbiter #(.NUM_REQ(NR), .CREDITS(CR)) dut (
    .clk_in(clk), .rst_in(rst_n), .req_valid_in(req_valid), .req_vertex_in(req_vertex),
    .req_ready_out(req_ready), .credit_in(credit), .valid_out(valid_out),
    .vertex_out(vertex_out), .source_out(source_out), .last_out(last_out),
    .busy_out(busy), .error_out(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 128'(valid_out), 128'(0));
    chk("rst_ready", 128'(req_ready), 128'(0));
    chk("rst_busy",  128'(busy), 128'(0));
    chk("rst_vertex", vertex_out, 128'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic collect(input int n);
    srcs.delete();
    repeat (n) begin
      tick();
      if (valid_out) srcs.push_back(int'(source_out));
    end
  endtask

  // Transaction-level reference: one step per clock edge from the sampled inputs.
  always @(posedge clk or negedge rst_n) begin : model
    int own, snt, crd, lg, pick;
    bit granted;
    if (!rst_n) begin
      m_owner <= -1; m_sent <= 0; m_credits <= CR; m_lastg <= NR - 1; m_err <= 1'b0;
      e_valid <= 1'b0; e_last <= 1'b0; e_vertex <= '0; e_source <= 0;
    end else begin
      own = m_owner; snt = m_sent; crd = m_credits; lg = m_lastg; granted = 1'b0;
      e_valid <= 1'b0;
      e_last  <= 1'b0;
      if (own < 0) begin
        if (crd > 0 && req_valid != '0) begin
          pick = -1;
          for (int k = 1; k <= NR; k++)
            if (pick < 0 && req_valid[(lg + k) % NR]) pick = (lg + k) % NR;
          own = pick; lg = pick; snt = 0; granted = 1'b1;
        end
      end else if (req_valid[own]) begin
        snt++;
        e_valid  <= 1'b1;
        e_vertex <= req_vertex[own];
        e_source <= own;
        e_last   <= (snt == 3);
        if (snt == 3) own = -1;
      end
      if (credit && !granted) begin
        if (crd == CR) m_err <= 1'b1;
        else crd++;
      end else if (granted && !credit) begin
        crd--;
      end
      m_owner <= own; m_sent <= snt; m_credits <= crd; m_lastg <= lg;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",  128'(req_ready), (m_owner >= 0) ? (128'(1) << m_owner) : 128'(0));
      chk("busy",   128'(busy), 128'(m_owner >= 0));
      chk("valid",  128'(valid_out), 128'(e_valid));
      chk("last",   128'(last_out), 128'(e_last));
      chk("error",  128'(error), 128'(m_err));
      chk("source", 128'(source_out), 128'(e_source));
      chk("vertex", vertex_out, e_vertex);
    end
  end

  initial begin
    logic [127:0] v0, v1, v2;
    int exp4[$];
    v0 = 128'h3f800000_40000000_40400000_40800000;
    v1 = 128'h11111111_22222222_33333333_44444444;
    v2 = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    rst_n = 1'b0; req_valid = '0; req_vertex = '0; credit = 1'b0;
    tick();
    chk_en = 1;
    tick();
    chk("reset_valid", 128'(valid_out), 128'(0));
    chk("reset_error", 128'(error), 128'(0));
    chk("reset_ready", 128'(req_ready), 128'(0));
    #2 rst_n = 1'b1;

    // Single triangle from requester 0.
    req_valid = 3'b001; req_vertex[0] = v0;
    tick();
    chk("t1_ready0", 128'(req_ready), 128'(3'b001));
    chk("t1_no_beat", 128'(valid_out), 128'(0));
    tick();
    chk("t1_beat1", {valid_out, last_out, 126'(source_out)}, {1'b1, 1'b0, 126'(0)});
    chk("t1_vtx1", vertex_out, v0);
    req_vertex[0] = v1;
    tick();
    chk("t1_vtx2", vertex_out, v1);
    req_vertex[0] = v2;
    tick();
    chk("t1_beat3_last", 128'(last_out), 128'(1));
    chk("t1_vtx3", vertex_out, v2);
    req_valid = '0;
    tick();
    chk("t1_idle", 128'({valid_out, busy}), 128'(0));

    // Grant held across a valid gap while another requester waits.
    do_reset();
    req_valid = 3'b001;
    tick(); tick();
    req_valid = 3'b010;
    repeat (4) begin
      tick();
      chk("t3_hold", 128'(req_ready), 128'(3'b001));
    end
    req_valid = 3'b001;
    tick(); tick();
    chk("t3_done_last", 128'({last_out, 2'(source_out)}), 128'({1'b1, 2'd0}));
    req_valid = '0;
    tick(); tick();

    // Credit exhaustion with two streaming requesters, then one returned credit.
    do_reset();
    req_valid = 3'b011;
    collect(30);
    exp4 = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    chk("t4_beats", 128'(srcs.size()), 128'(9));
    foreach (exp4[i]) chk("t4_src", 128'((i < srcs.size()) ? srcs[i] : -1), 128'(exp4[i]));
    chk("t4_stalled", 128'({valid_out, busy}), 128'(0));
    credit = 1'b1;
    tick();
    credit = 1'b0;
    collect(15);
    chk("t4_extra_beats", 128'(srcs.size()), 128'(3));
    chk("t4_extra_src", 128'((srcs.size() > 0) ? srcs[0] : -1), 128'(1));

    // Credit at full saturates and sets the sticky error; credit with a grant cancels.
    do_reset();
    req_valid = '0;
    credit = 1'b1;
    tick();
    credit = 1'b0;
    chk("t5_error", 128'(error), 128'(1));
    repeat (3) tick();
    chk("t5_sticky", 128'(error), 128'(1));
    req_valid = 3'b011;
    collect(30);
    chk("t5_no_extra_credit", 128'(srcs.size()), 128'(9));
    credit = 1'b1;
    tick();
    tick();
    credit = 1'b0;
    collect(20);
    chk("t5_grant_plus_credit", 128'(srcs.size()), 128'(6));
    req_valid = '0;

    // Reset mid-triangle after two vertices.
    do_reset();
    req_valid = 3'b001;
    tick(); tick(); tick();
    do_reset();
    req_valid = 3'b011;
    tick();
    chk("t6_regrant0", 128'(req_ready), 128'(3'b001));
    tick(); tick();
    chk("t6_beat2_notlast", 128'(last_out), 128'(0));
    tick();
    chk("t6_beat3_last", 128'({last_out, 2'(source_out)}), 128'({1'b1, 2'd0}));
    req_valid = '0;

    // Randomized traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      tick();
      for (int r = 0; r < NR; r++) begin
        req_valid[r] = ($urandom_range(0, 9) < 7);
        req_vertex[r] = {$urandom, $urandom, $urandom, $urandom};
      end
      credit = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        tick();
        #2 rst_n = 1'b1;
      end
    end
    req_valid = '0; credit = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
